soc_mem_decoder: RTL
====================

SOC_MEM_DECODER -- requirements
Module: soc_mem_decoder

Interface
REQ-001 Parameter RAM_AW, default 12, word-address width of on-chip RAM (4*2^RAM_AW bytes).
REQ-002 Parameter TIMEOUT, default 255, maximum IO-phase cycles before abort; legal range 1..65535.
REQ-003 Parameter ERR_DATA, default 32'hDEAD_BEEF, read data returned on any bus error.
REQ-004 Ports, listed as name, direction, width, meaning:
- clk in 1: sole clock.
- reset_ in 1: asynchronous active-low reset.
- mem_cmd_valid in 1: upstream command valid.
- mem_cmd_ready out 1: command accepted.
- mem_cmd_instr in 1: fetch tag, ignored.
- mem_cmd_wr in 1: 1 = write.
- mem_cmd_addr in 32: byte address.
- mem_cmd_wdata in 32: write data.
- mem_cmd_be in 4: byte enables.
- mem_rsp_ready out 1: one-cycle read-response pulse.
- mem_rsp_rdata out 32: read data, valid with mem_rsp_ready.
- ram_rd out 1: RAM read enable.
- ram_wr out 1: RAM write enable.
- ram_addr out RAM_AW: RAM word address.
- ram_wdata out 32: RAM write data.
- ram_be out 4: RAM byte enables.
- ram_rdata in 32: RAM data, valid the cycle after ram_rd.
- io_cmd_valid out 1: IO command valid.
- io_cmd_ready in 1: IO command accepted.
- io_cmd_wr out 1: IO write.
- io_cmd_addr out 32: IO address.
- io_cmd_wdata out 32: IO write data.
- io_cmd_be out 4: IO byte enables.
- io_rsp_ready in 1: IO read data valid.
- io_rsp_rdata in 32: IO read data.
- bus_err out 1: one-cycle error pulse.

Function
REQ-005 Decode on addr[31:28]: 4'h0 = RAM (word index addr[RAM_AW+1:2], upper bits alias), 4'hF = IO, else unmapped; addr[1:0] ignored.
REQ-006 States: IDLE, RAM_RD, IO_CMD, IO_RSP, ERR_RSP; reset to IDLE.
REQ-007 mem_cmd_ready = 1 in IDLE regardless of mem_cmd_valid, 0 in all other states; every IDLE command is accepted in its presentation cycle.
REQ-008 IDLE, valid, RAM write: ram_wr=1 combinationally with ram_addr/wdata/be driven from mem_cmd; stay IDLE; no response.
REQ-009 IDLE, valid, RAM read: ram_rd=1 same cycle -> RAM_RD; next cycle register mem_rsp_rdata<=ram_rdata, mem_rsp_ready<=1 -> IDLE; response two cycles after acceptance.
REQ-010 IDLE, valid, IO: register addr/wdata/be/wr into io_cmd_* -> IO_CMD; io_cmd_valid=1 from the next cycle, fields stable until io_cmd_ready.
REQ-011 IO_CMD with io_cmd_ready: write -> IDLE (posted); read -> IO_RSP, io_cmd_valid deasserted the following cycle.
REQ-012 IO_RSP with io_rsp_ready: register rdata, pulse mem_rsp_ready next cycle -> IDLE.
REQ-013 Timeout counter cleared on IO entry, incremented each cycle in IO_CMD/IO_RSP, cleared on io_cmd_ready; on reaching TIMEOUT without a handshake: drop io_cmd_valid, bus_err pulse, read returns ERR_DATA with mem_rsp_ready; -> IDLE.
REQ-014 Unmapped write: dropped, bus_err pulse next cycle, stay IDLE; unmapped read -> ERR_RSP, next cycle bus_err + mem_rsp_ready with ERR_DATA -> IDLE.
REQ-015 mem_rsp_ready and bus_err are registered single-cycle pulses; at most one read outstanding.
REQ-016 io_rsp_ready outside IO_RSP ignored; io_cmd_ready and timeout in the same cycle: handshake wins.

Reset
REQ-017 reset_ low asynchronously forces IDLE, counter 0, all registered outputs 0 (mem_rsp_rdata=0, io_cmd_valid=0, io_cmd_* fields 0, bus_err=0).
REQ-018 Reset mid-transaction abandons it without a response or bus_err; first cycle after release accepts commands.

Verification
REQ-019 RAM write 0x0000_0010 wdata 0x1234_5678 be 4'hF, then read same -> ram_wr/ram_addr=4 in acceptance cycle; mem_rsp_ready with 0x1234_5678 two cycles after read acceptance.
REQ-020 IO read 0xF000_0004, io_cmd_ready after 3 cycles, io_rsp_ready with 0xCAFE_0001 2 cycles later -> one mem_rsp_ready pulse with 0xCAFE_0001, mem_cmd_ready 0 throughout.
REQ-021 IO write, io_cmd_ready never asserted, TIMEOUT=8 -> io_cmd_valid dropped after 8 cycles, one bus_err pulse, no mem_rsp_ready.
REQ-022 Read 0x8000_0000 -> bus_err and mem_rsp_ready with 0xDEAD_BEEF next cycle; write 0x8000_0000 -> bus_err only, no RAM or IO strobe.
REQ-023 reset_ low while in IO_RSP -> io_cmd_valid and mem_rsp_ready immediately 0; after release, a RAM read completes normally.

Source files
------------

// File: rtl/soc_mem_decoder.sv
// Address decoder that splits a simple memory command bus between on-chip RAM,
// an IO port with a handshake and timeout, and an error responder for unmapped space.
module soc_mem_decoder #(
    parameter int          RAM_AW   = 12,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              mem_cmd_valid,
    output logic              mem_cmd_ready,
    input  logic              mem_cmd_instr,
    input  logic              mem_cmd_wr,
    input  logic [31:0]       mem_cmd_addr,
    input  logic [31:0]       mem_cmd_wdata,
    input  logic [3:0]        mem_cmd_be,
    output logic              mem_rsp_ready,
    output logic [31:0]       mem_rsp_rdata,
    output logic              ram_rd,
    output logic              ram_wr,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic [3:0]        ram_be,
    input  logic [31:0]       ram_rdata,
    output logic              io_cmd_valid,
    input  logic              io_cmd_ready,
    output logic              io_cmd_wr,
    output logic [31:0]       io_cmd_addr,
    output logic [31:0]       io_cmd_wdata,
    output logic [3:0]        io_cmd_be,
    input  logic              io_rsp_ready,
    input  logic [31:0]       io_rsp_rdata,
    output logic              bus_err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RAM_RD  = 3'd1,
        IO_CMD  = 3'd2,
        IO_RSP  = 3'd3,
        ERR_RSP = 3'd4
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t      state_reg;
    logic [15:0] tmo_cnt_reg;
    logic        accept;
    logic        is_ram;
    logic        is_io;
    logic        tmo_hit;
    logic        unused_bits;

    assign is_ram  = (mem_cmd_addr[31:28] == 4'h0);
    assign is_io   = (mem_cmd_addr[31:28] == 4'hF);
    assign accept  = (state_reg == IDLE) && mem_cmd_valid;
    assign tmo_hit = (tmo_cnt_reg == TMO_LAST);

    // RAM strobes are combinational so writes never cost a cycle of bus occupancy.
    assign mem_cmd_ready = (state_reg == IDLE);
    assign ram_wr        = accept && is_ram && mem_cmd_wr;
    assign ram_rd        = accept && is_ram && !mem_cmd_wr;
    assign ram_addr      = mem_cmd_addr[RAM_AW+1:2];
    assign ram_wdata     = mem_cmd_wdata;
    assign ram_be        = mem_cmd_be;

    assign unused_bits = ^{mem_cmd_instr, mem_cmd_addr[27:RAM_AW+2], mem_cmd_addr[1:0]};

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_reg     <= IDLE;
            tmo_cnt_reg   <= 16'd0;
            mem_rsp_ready <= 1'b0;
            mem_rsp_rdata <= 32'd0;
            io_cmd_valid  <= 1'b0;
            io_cmd_wr     <= 1'b0;
            io_cmd_addr   <= 32'd0;
            io_cmd_wdata  <= 32'd0;
            io_cmd_be     <= 4'd0;
            bus_err       <= 1'b0;
        end else begin
            mem_rsp_ready <= 1'b0;
            bus_err       <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (mem_cmd_valid) begin
                        if (is_ram) begin
                            if (!mem_cmd_wr) state_reg <= RAM_RD;
                        end else if (is_io) begin
                            io_cmd_valid <= 1'b1;
                            io_cmd_wr    <= mem_cmd_wr;
                            io_cmd_addr  <= mem_cmd_addr;
                            io_cmd_wdata <= mem_cmd_wdata;
                            io_cmd_be    <= mem_cmd_be;
                            tmo_cnt_reg  <= 16'd0;
                            state_reg    <= IO_CMD;
                        end else begin
                            // Unmapped: error pulse next cycle; reads also get a response.
                            bus_err <= 1'b1;
                            if (!mem_cmd_wr) begin
                                mem_rsp_ready <= 1'b1;
                                mem_rsp_rdata <= ERR_DATA;
                                state_reg     <= ERR_RSP;
                            end
                        end
                    end
                end
                RAM_RD: begin
                    mem_rsp_ready <= 1'b1;
                    mem_rsp_rdata <= ram_rdata;
                    state_reg     <= IDLE;
                end
                IO_CMD: begin
                    if (io_cmd_ready) begin
                        io_cmd_valid <= 1'b0;
                        tmo_cnt_reg  <= 16'd0;
                        state_reg    <= io_cmd_wr ? IDLE : IO_RSP;
                    end else if (tmo_hit) begin
                        io_cmd_valid <= 1'b0;
                        bus_err      <= 1'b1;
                        if (!io_cmd_wr) begin
                            mem_rsp_ready <= 1'b1;
                            mem_rsp_rdata <= ERR_DATA;
                        end
                        state_reg <= IDLE;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
                    end
                end
                IO_RSP: begin
                    if (io_rsp_ready) begin
                        mem_rsp_ready <= 1'b1;
                        mem_rsp_rdata <= io_rsp_rdata;
                        state_reg     <= IDLE;
                    end else if (tmo_hit) begin
                        bus_err       <= 1'b1;
                        mem_rsp_ready <= 1'b1;
                        mem_rsp_rdata <= ERR_DATA;
                        state_reg     <= IDLE;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
                    end
                end
                ERR_RSP: state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
